// File: rtl/piezo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : piezo_pkg
//  Purpose  : Shared definitions for the piezo melody player: game FSM state
//             codes, 50 MHz note divisors, note-entry layout, player states.
//  Revision : 1.0 - initial release
// ============================================================================
package piezo_pkg;

  // State codes shared with the game FSM
  localparam int START_SPIN   = 4;
  localparam int SPIN_WAIT    = 5;
  localparam int WIN_DISPLAY  = 7;
  localparam int LOSE_DISPLAY = 8;

  // Half-period divisors for a 50 MHz system clock
  localparam int NOTE_C4   = 95557;
  localparam int NOTE_E4   = 75843;
  localparam int NOTE_G4   = 63776;
  localparam int NOTE_A4   = 56818;
  localparam int NOTE_C5   = 47778;
  localparam int NOTE_REST = 0;

  // Storage widths of one note-table entry
  localparam int NOTE_DIV_W = 20;
  localparam int NOTE_DUR_W = 10;

  // dur == 0 marks the end of a sequence; div == 0 is a rest
  typedef struct packed {
    logic [NOTE_DIV_W-1:0] div;
    logic [NOTE_DUR_W-1:0] dur;
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TONE = 2'd2,
    ST_GAP  = 2'd3
  } play_state_t;

  function automatic note_t mk_note(input int div, input int dur);
    note_t n;
    n.div = NOTE_DIV_W'(div);
    n.dur = NOTE_DUR_W'(dur);
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/piezo_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : piezo_tone_gen
//  Purpose  : Square-wave generator. Half-period counter runs 0..div-1 and
//             toggles the output, giving f = clk / (2*div). clr or div==0
//             forces the counter and output low.
//  Revision : 1.0 - initial release
// ============================================================================
module piezo_tone_gen #(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_en,
  input  logic             i_clr,
  output logic             o_wave
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_wave;

  // Half-period counter and output toggle; clear wins over enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (i_clr || (i_div == '0)) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == (i_div - DIV_W'(1))) begin
        r_cnt  <= '0;
        r_wave <= ~r_wave;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign o_wave = r_wave;

endmodule
`default_nettype wire

// File: rtl/piezo_melody_player.sv
`default_nettype none
// ============================================================================
//  Module   : piezo_melody_player
//  Purpose  : Sequences notes from a fixed table onto the piezo pin. One-shot
//             or looping playback, pre-emption by start, abort by stop.
//  Revision : 1.0 - initial release
// ============================================================================
module piezo_melody_player
  import piezo_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int DIV_W   = 20,
  parameter int DUR_W   = 10,
  parameter int GAP_T   = 20,
  parameter int SEQ_LEN = 8,
  parameter int NUM_SEQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [$clog2(NUM_SEQ)-1:0] i_seq_sel,
  input  logic                       i_loop,
  input  logic                       i_stop,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [$clog2(SEQ_LEN)-1:0] o_note_idx,
  output logic                       o_piezo
);

  localparam int SEL_W    = $clog2(NUM_SEQ);
  localparam int IDX_W    = $clog2(SEQ_LEN);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W    = (GAP_T > 0) ? $clog2(GAP_T + 1) : 1;

  play_state_t        r_state, w_next;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic               w_tick;
  logic [SEL_W-1:0]   r_seq, w_seq_nxt;
  logic               r_loop, w_loop_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [DUR_W-1:0]   r_dur, w_dur_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic               r_done, w_done_nxt;
  logic               w_note_end, w_seq_end;
  int                 w_rom_addr;
  note_t              w_note;
  logic [DIV_W-1:0]   w_div;

  // Free-running duration prescaler; only reset clears its phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TICK_W'(1);
  end

  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  // Note table ROM indexed by {sequence, note index}; unlisted entries are end markers
  always_comb begin
    w_rom_addr = int'(r_seq) * SEQ_LEN + int'(r_idx);
    w_note     = '0;
    case (w_rom_addr)
      // sequence 0: empty
      // sequence 1: single note
      8:  w_note = mk_note(5, 3);
      // sequence 2: tone then rest
      16: w_note = mk_note(4, 2);
      17: w_note = mk_note(NOTE_REST, 1);
      // sequence 3: full length, no end marker
      24: w_note = mk_note(3, 1);
      25: w_note = mk_note(2, 1);
      26: w_note = mk_note(NOTE_REST, 1);
      27: w_note = mk_note(3, 1);
      28: w_note = mk_note(2, 1);
      29: w_note = mk_note(3, 1);
      30: w_note = mk_note(2, 1);
      31: w_note = mk_note(3, 1);
      default: w_note = '0;
    endcase
  end

  assign w_div = DIV_W'(w_note.div);

  // Player state register and per-sequence context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_seq   <= '0;
      r_loop  <= 1'b0;
      r_idx   <= '0;
      r_dur   <= '0;
      r_gap   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_seq   <= w_seq_nxt;
      r_loop  <= w_loop_nxt;
      r_idx   <= w_idx_nxt;
      r_dur   <= w_dur_nxt;
      r_gap   <= w_gap_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: stop beats start, start pre-empts any state
  always_comb begin
    w_next     = r_state;
    w_seq_nxt  = r_seq;
    w_loop_nxt = r_loop;
    w_idx_nxt  = r_idx;
    w_dur_nxt  = r_dur;
    w_gap_nxt  = r_gap;
    w_done_nxt = 1'b0;
    w_note_end = 1'b0;
    w_seq_end  = 1'b0;
    if (i_stop) begin
      w_next = ST_IDLE;
    end else if (i_start) begin
      w_next     = ST_LOAD;
      w_seq_nxt  = i_seq_sel;
      w_loop_nxt = i_loop;
      w_idx_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_IDLE;
        ST_LOAD: begin
          if (w_note.dur == '0) begin
            w_seq_end = 1'b1;
          end else begin
            w_next    = ST_TONE;
            w_dur_nxt = DUR_W'(w_note.dur);
          end
        end
        ST_TONE: begin
          if (r_dur == '0) begin
            if (GAP_T > 0) begin
              w_next    = ST_GAP;
              w_gap_nxt = GAP_W'(GAP_T);
            end else begin
              w_note_end = 1'b1;
            end
          end else if (w_tick) begin
            w_dur_nxt = r_dur - DUR_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gap == '0)  w_note_end = 1'b1;
          else if (w_tick)  w_gap_nxt  = r_gap - GAP_W'(1);
        end
        default: w_next = ST_IDLE;
      endcase

      // The last table slot ends the sequence just like an end marker
      if (w_note_end) begin
        if (r_idx == IDX_W'(SEQ_LEN - 1)) begin
          w_seq_end = 1'b1;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
          w_next    = ST_LOAD;
        end
      end

      if (w_seq_end) begin
        if (r_loop) begin
          w_idx_nxt = '0;
          w_next    = ST_LOAD;
        end else begin
          w_done_nxt = 1'b1;
          w_next     = ST_IDLE;
        end
      end
    end
  end

  // Tone generator is held clear whenever the next cycle is not a tone,
  // so every note starts low and gaps/stop silence the pin immediately.
  piezo_tone_gen #(
    .DIV_W (DIV_W)
  ) u_tone (
    .clk    (clk),
    .rst    (rst),
    .i_div  (w_div),
    .i_en   (r_state == ST_TONE),
    .i_clr  (w_next != ST_TONE),
    .o_wave (o_piezo)
  );

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_note_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_piezo_melody_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piezo_melody_player
//  Purpose  : Directed self-checking bench for piezo_melody_player with a
//             10 kHz clock and 1 kHz tick (tick every 10 clocks), GAP_T=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piezo_melody_player;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [1:0] i_seq_sel = 2'd0;
  logic       i_loop = 1'b0;
  logic       i_stop = 1'b0;
  logic       o_busy, o_done, o_piezo;
  logic [2:0] o_note_idx;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;      // clock edges since reset release (prescaler phase)
  int   t0 = 0;       // edge at which the current start was sampled
  int   n_rise = 0;
  int   n_done = 0;
  logic prev_piezo = 1'b0;

  always #5 clk = ~clk;

  piezo_melody_player #(
    .CLK_HZ  (10_000),
    .TICK_HZ (1000),
    .DIV_W   (20),
    .DUR_W   (10),
    .GAP_T   (2),
    .SEQ_LEN (8),
    .NUM_SEQ (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_seq_sel  (i_seq_sel),
    .i_loop     (i_loop),
    .i_stop     (i_stop),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_note_idx (o_note_idx),
    .o_piezo    (o_piezo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (o_piezo === 1'b1 && prev_piezo === 1'b0) n_rise++;
    if (o_done === 1'b1) n_done++;
    prev_piezo = o_piezo;
  endtask

  task automatic step_to(input int rel);
    while (cyc < t0 + rel) step();
  endtask

  // Start sampled on a tick edge so note timing is fixed relative to t0
  task automatic start_seq(input logic [1:0] sel, input logic lp);
    while (cyc % 10 != 9) step();
    i_seq_sel = sel;
    i_loop    = lp;
    i_start   = 1'b1;
    step();
    i_start = 1'b0;
    t0      = cyc;
    n_rise  = 0;
    n_done  = 0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    cyc        = 0;
    prev_piezo = 1'b0;
  endtask

  initial begin
    // ---------------- reset values ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_piezo", o_piezo, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_idx", o_note_idx, 0);
    release_reset();

    // ---------------- 1: reset asserted mid-tone ----------------
    start_seq(2'd1, 1'b0);
    step_to(7);
    check("t1_piezo_high_before_rst", o_piezo, 1);
    check("t1_busy_before_rst", o_busy, 1);
    #3 rst = 1'b1;
    #1;
    check("t1_piezo_async", o_piezo, 0);
    check("t1_busy_async", o_busy, 0);
    check("t1_idx_async", o_note_idx, 0);
    release_reset();
    n_rise = 0;
    n_done = 0;
    repeat (25) step();
    check("t1_idle_busy", o_busy, 0);
    check("t1_idle_rises", n_rise, 0);
    check("t1_idle_done", n_done, 0);

    // ---------------- 2: one-shot seq 1 {5,3},{end} ----------------
    start_seq(2'd1, 1'b0);
    check("t2_busy_latency", o_busy, 1);
    step_to(5);
    check("t2_piezo_before_toggle", o_piezo, 0);
    step_to(6);
    check("t2_first_toggle", o_piezo, 1);
    step_to(11);
    check("t2_half_period", o_piezo, 0);
    step_to(51);
    check("t2_busy_end_gap", o_busy, 1);
    check("t2_idx_after_note", o_note_idx, 1);
    check("t2_rises", n_rise, 3);
    step_to(52);
    check("t2_done", o_done, 1);
    check("t2_busy_off", o_busy, 0);
    step_to(53);
    check("t2_done_one_cycle", o_done, 0);
    check("t2_done_count", n_done, 1);

    // ---------------- empty sequence 0 ----------------
    start_seq(2'd0, 1'b0);
    check("t0_busy", o_busy, 1);
    check("t0_done_early", o_done, 0);
    step_to(1);
    check("t0_done", o_done, 1);
    check("t0_busy_off", o_busy, 0);
    step_to(2);
    check("t0_done_clear", o_done, 0);
    check("t0_rises", n_rise, 0);

    // ---------------- 3: looping seq 2 {4,2},{rest,1},{end} ----------------
    start_seq(2'd2, 1'b1);
    step_to(5);
    check("t3_first_toggle", o_piezo, 1);
    step_to(45);
    check("t3_idx_rest", o_note_idx, 1);
    step_to(60);
    check("t3_rest_silent", o_piezo, 0);
    step_to(75);
    check("t3_loop_idx", o_note_idx, 0);
    check("t3_loop_busy", o_busy, 1);
    step_to(86);
    check("t3_loop_piezo", o_piezo, 1);
    check("t3_loop_rises", n_rise, 4);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check("t3_stop_piezo", o_piezo, 0);
    check("t3_stop_busy", o_busy, 0);
    check("t3_no_done", n_done, 0);

    // ---------------- 4+5: pre-empt seq 1 with full-length seq 3 ----------------
    start_seq(2'd1, 1'b0);
    step_to(9);
    check("t4_seq1_playing", o_piezo, 1);
    i_seq_sel = 2'd3;
    i_start   = 1'b1;
    step();
    i_start = 1'b0;
    t0 = cyc;
    check("t4_preempt_piezo", o_piezo, 0);
    check("t4_preempt_idx", o_note_idx, 0);
    check("t4_preempt_busy", o_busy, 1);
    step_to(3);
    check("t4_seq3_pre_toggle", o_piezo, 0);
    step_to(4);
    check("t4_seq3_div", o_piezo, 1);
    step_to(6);
    check("t5_idx_0", o_note_idx, 0);
    for (int k = 1; k < 8; k++) begin
      step_to(7 + 30 * k);
      check($sformatf("t5_idx_%0d", k), o_note_idx, k);
    end
    step_to(240);
    check("t5_busy_last_gap", o_busy, 1);
    check("t5_no_early_done", n_done, 0);
    step_to(241);
    check("t5_done", o_done, 1);
    check("t5_busy_off", o_busy, 0);
    step_to(242);
    check("t5_done_count", n_done, 1);

    // ---------------- 6: stop and start together while busy ----------------
    start_seq(2'd1, 1'b0);
    step_to(5);
    i_stop    = 1'b1;
    i_start   = 1'b1;
    i_seq_sel = 2'd2;
    step();
    i_stop  = 1'b0;
    i_start = 1'b0;
    check("t6_busy", o_busy, 0);
    check("t6_piezo", o_piezo, 0);
    n_rise = 0;
    step_to(70);
    check("t6_stay_idle", o_busy, 0);
    check("t6_no_rises", n_rise, 0);
    check("t6_no_done", n_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
